// File: rtl/stack_unit_param.sv
// Parametrised hardware stack: array storage, entry count and registered top-of-stack.
// Ports: op_i/data_i/clear_i in; top_o, sp_o, empty_o, full_o, pop_valid_o, pop_data_o, overflow_o, underflow_o out.
module stack_unit_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  system1000,
  input  logic                  system1000_rstn,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] top_o,
  output logic [ADDR_WIDTH:0]   sp_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  pop_valid_o,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] SpFull = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   sp;
  logic [ADDR_WIDTH:0]   spM1;
  logic [ADDR_WIDTH:0]   spM2;
  logic [DATA_WIDTH-1:0] top;
  logic [DATA_WIDTH-1:0] popData;
  logic [DATA_WIDTH-1:0] below;
  logic                  popValid;
  logic                  overflow;
  logic                  underflow;
  logic                  isEmpty;
  logic                  isFull;
  logic                  doPush;
  logic                  doPop;
  logic                  doRep;
  logic                  pushErr;
  logic                  popErr;

  assign isEmpty = (sp == '0);
  assign isFull  = (sp == SpFull);
  assign spM1    = sp - 1'b1;
  assign spM2    = sp - 2'd2;

  // Entry just under the top; only meaningful when sp >= 2.
  assign below = mem[spM2[ADDR_WIDTH-1:0]];

  assign doPush  = (op_i == 2'b01) && !isFull;
  assign pushErr = (op_i == 2'b01) && isFull;
  assign doPop   = (op_i == 2'b10) && !isEmpty;
  assign doRep   = (op_i == 2'b11) && !isEmpty;
  assign popErr  = op_i[1] && isEmpty;

  // Old top spills into the array when a push lands on a non-empty stack.
  always_ff @(posedge system1000) begin
    if (!clear_i && doPush && !isEmpty) begin
      mem[spM1[ADDR_WIDTH-1:0]] <= top;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sp        <= '0;
      top       <= '0;
      popData   <= '0;
      popValid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear_i) begin
      sp        <= '0;
      top       <= '0;
      popValid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      popValid <= 1'b0;
      unique case (1'b1)
        doPush: begin
          top <= data_i;
          sp  <= sp + 1'b1;
        end
        pushErr: overflow <= 1'b1;
        doPop: begin
          popData  <= top;
          popValid <= 1'b1;
          sp       <= spM1;
          top      <= (sp >= 2) ? below : '0;
        end
        doRep: begin
          popData  <= top;
          popValid <= 1'b1;
          top      <= data_i;
        end
        popErr:  underflow <= 1'b1;
        default: ;
      endcase
    end
  end

  assign top_o       = top;
  assign sp_o        = sp;
  assign empty_o     = isEmpty;
  assign full_o      = isFull;
  assign pop_valid_o = popValid;
  assign pop_data_o  = popData;
  assign overflow_o  = overflow;
  assign underflow_o = underflow;

endmodule

// File: tb/tb_stack_unit_param.sv
// Testbench for stack_unit_param: vector table, directed corners,
// and random ops checked against a queue-based model.
module tb_stack_unit_param;

  localparam int DW = 16;
  localparam int AW = 7;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          rstn;
  logic [1:0]    opI;
  logic [DW-1:0] dataI;
  logic          clearI;
  logic [DW-1:0] topO;
  logic [AW:0]   spO;
  logic          emptyO;
  logic          fullO;
  logic          popValidO;
  logic [DW-1:0] popDataO;
  logic          overflowO;
  logic          underflowO;

  stack_unit_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .op_i            (opI),
    .data_i          (dataI),
    .clear_i         (clearI),
    .top_o           (topO),
    .sp_o            (spO),
    .empty_o         (emptyO),
    .full_o          (fullO),
    .pop_valid_o     (popValidO),
    .pop_data_o      (popDataO),
    .overflow_o      (overflowO),
    .underflow_o     (underflowO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [DW-1:0] q[$];
  logic          mPv = 1'b0;
  logic [DW-1:0] mPd = '0;
  logic          mOvf = 1'b0;
  logic          mUnf = 1'b0;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] d;
    logic          clr;
    logic [DW-1:0] expTop;
    int            expSp;
    logic          expPv;
    logic [DW-1:0] expPd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mPv = 1'b0;
    mPd = '0;
    mOvf = 1'b0;
    mUnf = 1'b0;
  endtask

  task automatic modelStep(input logic [1:0] op, input logic [DW-1:0] d,
                           input logic clr);
    if (clr) begin
      q.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
      mPv = 1'b0;
    end else begin
      mPv = 1'b0;
      case (op)
        2'b01: if (q.size() == DEPTH) mOvf = 1'b1; else q.push_back(d);
        2'b10:
          if (q.size() == 0) mUnf = 1'b1;
          else begin
            mPd = q.pop_back();
            mPv = 1'b1;
          end
        2'b11:
          if (q.size() == 0) mUnf = 1'b1;
          else begin
            mPd = q[$];
            q[$] = d;
            mPv = 1'b1;
          end
        default: ;
      endcase
    end
  endtask

  function automatic logic [DW-1:0] mTop();
    return (q.size() == 0) ? '0 : q[$];
  endfunction

  task automatic checkAll();
    chk("top", 32'(topO), 32'(mTop()));
    chk("sp", 32'(spO), 32'(q.size()));
    chk("empty", 32'(emptyO), 32'(q.size() == 0));
    chk("full", 32'(fullO), 32'(q.size() == DEPTH));
    chk("popValid", 32'(popValidO), 32'(mPv));
    chk("popData", 32'(popDataO), 32'(mPd));
    chk("overflow", 32'(overflowO), 32'(mOvf));
    chk("underflow", 32'(underflowO), 32'(mUnf));
  endtask

  task automatic step(input logic [1:0] op, input logic [DW-1:0] d,
                      input logic clr);
    opI = op;
    dataI = d;
    clearI = clr;
    @(posedge clk);
    modelStep(op, d, clr);
    #1;
    checkAll();
  endtask

  vec_t vecs[$];

  initial begin
    int r;
    int mode;
    rstn = 1'b0;
    opI = 2'b00;
    dataI = '0;
    clearI = 1'b0;
    modelReset();
    #1;
    checkAll();
    #12 rstn = 1'b1;

    // push/pop order, replace, clear-beats-op
    vecs.push_back('{2'b01, 16'h0011, 0, 16'h0011, 1, 0, 16'h0000});
    vecs.push_back('{2'b01, 16'h0022, 0, 16'h0022, 2, 0, 16'h0000});
    vecs.push_back('{2'b01, 16'h0033, 0, 16'h0033, 3, 0, 16'h0000});
    vecs.push_back('{2'b10, 16'h0000, 0, 16'h0022, 2, 1, 16'h0033});
    vecs.push_back('{2'b10, 16'h0000, 0, 16'h0011, 1, 1, 16'h0022});
    vecs.push_back('{2'b10, 16'h0000, 0, 16'h0000, 0, 1, 16'h0011});
    vecs.push_back('{2'b00, 16'h0000, 0, 16'h0000, 0, 0, 16'h0011});
    vecs.push_back('{2'b01, 16'h0005, 0, 16'h0005, 1, 0, 16'h0011});
    vecs.push_back('{2'b01, 16'h0007, 0, 16'h0007, 2, 0, 16'h0011});
    vecs.push_back('{2'b11, 16'h0009, 0, 16'h0009, 2, 1, 16'h0007});
    vecs.push_back('{2'b00, 16'h0000, 0, 16'h0009, 2, 0, 16'h0007});
    vecs.push_back('{2'b01, 16'h0001, 0, 16'h0001, 3, 0, 16'h0007});
    vecs.push_back('{2'b01, 16'h0044, 1, 16'h0000, 0, 0, 16'h0007});
    vecs.push_back('{2'b01, 16'h0055, 0, 16'h0055, 1, 0, 16'h0007});
    vecs.push_back('{2'b10, 16'h0000, 0, 16'h0000, 0, 1, 16'h0055});
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].op, vecs[i].d, vecs[i].clr);
      chk($sformatf("vec%0d.top", i), 32'(topO), 32'(vecs[i].expTop));
      chk($sformatf("vec%0d.sp", i), 32'(spO), 32'(vecs[i].expSp));
      chk($sformatf("vec%0d.pv", i), 32'(popValidO), 32'(vecs[i].expPv));
      chk($sformatf("vec%0d.pd", i), 32'(popDataO), 32'(vecs[i].expPd));
    end

    // underflow is sticky, does not block, cleared by clear
    step(2'b10, 16'h0, 1'b0);
    chk("uf.flag", 32'(underflowO), 32'd1);
    chk("uf.sp", 32'(spO), 32'd0);
    step(2'b01, 16'h00AA, 1'b0);
    chk("uf.pushSp", 32'(spO), 32'd1);
    chk("uf.sticky", 32'(underflowO), 32'd1);
    step(2'b00, 16'h0, 1'b1);
    chk("uf.cleared", 32'(underflowO), 32'd0);
    chk("uf.clrSp", 32'(spO), 32'd0);

    // fill to DEPTH, replace while full, overflow, drain
    for (int i = 0; i < DEPTH; i++) step(2'b01, DW'(i), 1'b0);
    chk("full.flag", 32'(fullO), 32'd1);
    chk("full.sp", 32'(spO), 32'(DEPTH));
    chk("full.top", 32'(topO), 32'(DEPTH - 1));
    step(2'b11, DW'(DEPTH - 1), 1'b0);
    chk("fullRep.pv", 32'(popValidO), 32'd1);
    chk("fullRep.pd", 32'(popDataO), 32'(DEPTH - 1));
    chk("fullRep.ovf", 32'(overflowO), 32'd0);
    step(2'b01, 16'hFFFF, 1'b0);
    chk("ovf.flag", 32'(overflowO), 32'd1);
    chk("ovf.top", 32'(topO), 32'(DEPTH - 1));
    chk("ovf.sp", 32'(spO), 32'(DEPTH));
    for (int i = DEPTH - 1; i >= 0; i--) begin
      step(2'b10, 16'h0, 1'b0);
      chk($sformatf("drain%0d", i), 32'(popDataO), 32'(i));
    end
    chk("drain.unf", 32'(underflowO), 32'd0);
    chk("drain.empty", 32'(emptyO), 32'd1);
    step(2'b00, 16'h0, 1'b1);

    // async reset between edges with 5 entries
    for (int i = 0; i < 5; i++) step(2'b01, DW'(16'h100 + i), 1'b0);
    chk("pre.sp", 32'(spO), 32'd5);
    #2 rstn = 1'b0;
    #1;
    modelReset();
    checkAll();
    chk("arst.sp", 32'(spO), 32'd0);
    chk("arst.top", 32'(topO), 32'd0);
    #2 rstn = 1'b1;
    step(2'b10, 16'h0, 1'b0);
    chk("arst.unf", 32'(underflowO), 32'd1);

    // random ops in phases biased toward fill and drain
    for (int n = 0; n < 3000; n++) begin
      mode = (n / 500) % 3;
      r = int'($urandom_range(0, 99));
      if (r < 2) step(2'b00, 16'h0, 1'b1);
      else if (mode == 0)
        step((r < 80) ? 2'b01 : 2'(r % 4), DW'($urandom), 1'b0);
      else if (mode == 1)
        step((r < 75) ? 2'b10 : 2'(r % 4), DW'($urandom), 1'b0);
      else step(2'(r % 4), DW'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_unit_param.md
Name: stack_unit_param

Overview:
- Parametrised hardware stack that replaces the processor's bare stack-pointer update.
- Owns storage, the pointer, a registered top-of-stack, and overflow/underflow detection.
- Supports push, pop and replace-top (pop-then-push in one cycle).
- Sits beside the ALU/decode path. Decode issues one 2-bit op per cycle; the stack returns top-of-stack and popped data.

Parameters:
DATA_WIDTH, 16, width of each stack entry
ADDR_WIDTH, 7, log2 of depth; DEPTH = 2**ADDR_WIDTH entries (default 128)

Ports:
system1000  input  1  clock, rising edge
system1000_rstn  input  1  asynchronous active-low reset
op_i  input  2  00 nop, 01 push, 10 pop, 11 replace (pop+push)
data_i  input  DATA_WIDTH  value pushed on push/replace
clear_i  input  1  synchronous flush to empty; also clears error flags
top_o  output  DATA_WIDTH  current top-of-stack (registered); 0 when empty
sp_o  output  ADDR_WIDTH+1  entry count, 0..DEPTH
empty_o  output  1  sp_o == 0
full_o  output  1  sp_o == DEPTH
pop_valid_o  output  1  one-cycle pulse: pop/replace accepted last cycle
pop_data_o  output  DATA_WIDTH  value removed by that pop/replace; holds until next accepted pop
overflow_o  output  1  sticky: push attempted while full
underflow_o  output  1  sticky: pop/replace attempted while empty

Behaviour:
Reset (system1000_rstn low, asynchronous):
- sp=0, top_o=0, pop_data_o=0, pop_valid_o=0, overflow_o=0, underflow_o=0.
- Storage array contents are don't-care and are not reset.

Storage:
- top_o is a register holding entry sp-1.
- The array holds entries 0..sp-2.
- Array read is combinational; array write is synchronous.

Timing:
- All updates occur on the rising edge following the cycle op_i is presented; latency is 1 cycle.
- empty_o and full_o are combinational decodes of the sp register.

Per-cycle priority: clear_i > op_i.
- clear_i=1: sp<=0, top<=0, both sticky flags<=0, pop_valid<=0. op_i is ignored that cycle.
- nop: no state change; pop_valid<=0.
- push, not full: if sp>0, array[sp-1]<=top. Then top<=data_i, sp<=sp+1.
- push, full: ignored; overflow<=1; state unchanged.
- pop, not empty: pop_data<=top, pop_valid<=1, sp<=sp-1. top<=array[sp-2] if sp>=2, else top<=0.
- pop, empty: ignored; underflow<=1; pop_valid<=0.
- replace, not empty: pop_data<=top, pop_valid<=1, top<=data_i; sp and array unchanged. Legal when full.
- replace, empty: ignored; underflow<=1.

pop_valid_o:
- Deasserts on any cycle without an accepted pop/replace.
- pop_data_o keeps its last value.

Sticky flags:
- Stay set until clear_i or reset.
- Errors do not block subsequent legal ops.

Width/wrap:
- sp is ADDR_WIDTH+1 bits, so DEPTH is representable.
- sp never wraps: increment is gated by full, decrement by empty.

Reset mid-operation:
- Asynchronous reset wins over any in-flight op.
- First op after release sees an empty stack.

No internal FSM beyond the pointer/flag registers. Implementation is a single always block plus the array.

Test Plan:
1. Reset, push 0x0011, 0x0022, 0x0033 on consecutive cycles -> sp_o=3, top_o=0x0033, empty_o=0. Then pop x3 -> pop_data_o sequence 0x0033, 0x0022, 0x0011 with pop_valid_o high each following cycle; final sp_o=0, top_o=0, empty_o=1.
2. Pop on empty stack -> sp_o stays 0, pop_valid_o=0, underflow_o=1. Later push 0x00AA succeeds (sp_o=1) and underflow_o stays 1. clear_i -> underflow_o=0, sp_o=0.
3. Push DEPTH (128) values i=0..127 -> full_o=1, sp_o=128, top_o=127. 129th push of 0xFFFF -> overflow_o=1, top_o=127, sp_o=128. Pop all -> values 127..0 in order, no underflow.
4. Replace on stack [5,7] (top 7) with data_i=9 -> pop_data_o=7, pop_valid_o=1, top_o=9, sp_o=2. Replace on full stack -> accepted, overflow_o stays 0.
5. clear_i asserted together with op_i=push on a 3-deep stack -> sp_o=0, top_o=0, no write; the next push lands as the sole entry.
6. Assert system1000_rstn low asynchronously between edges mid-sequence with sp_o=5 -> outputs go to reset values immediately. After release, pop -> underflow_o=1.
